// File: rtl/cacheline_adaptor.sv
// Bridges a cache-line port to a 4-beat burst memory port: reads gather beats into line_o,
// writes slice line_i into beats; one-cycle resp_o pulse after the last beat.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31-OFF_W:0]   addr_q;
  logic [LINE_W-1:0]   line_q;

  // Byte-offset bits are dropped: memory only sees line-aligned addresses.
  logic unused_offset;
  assign unused_offset = ^address_i[OFF_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_i || read_i) begin
            state_q <= write_i ? WRITE : READ;
            addr_q  <= address_i[31:OFF_W];
            cnt_q   <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_q[BURST_W*cnt_q +: BURST_W] <= burst_i;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) state_q <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = {addr_q, {OFF_W{1'b0}}};
  assign line_o    = line_q;
  // Write data follows line_i live so the beat reflects the current line contents.
  assign burst_o   = (state_q == WRITE) ? line_i[BURST_W*cnt_q +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed + randomized bench for cacheline_adaptor with a transaction-level reference model.
module tb_cacheline_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i, line_o;
  logic [31:0]   address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          read_o, write_o, resp_i;

  cacheline_adaptor #(.LINE_W(LW), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] beats [4];
  logic [LW-1:0] exp_line;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l = '0;
    for (int i = 0; i < LW / 32; i++) l = {l[LW-33:0], 32'($urandom)};
    return l;
  endfunction

  task automatic rand_beats();
    for (int i = 0; i < 4; i++) beats[i] = {32'($urandom), 32'($urandom)};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_o"}, read_o, 0);
    chk({tag, "_write_o"}, write_o, 0);
    chk({tag, "_resp_o"}, resp_o, 0);
    chk({tag, "_burst_o"}, burst_o, 0);
    chk({tag, "_addr_o"}, address_o, 0);
    chk({tag, "_line_o"}, line_o, 0);
  endtask

  // Full read transaction starting in IDLE; ends one cycle after resp_o (back in IDLE).
  task automatic do_read(input logic [31:0] addr, input int maxgap);
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFE0;
    read_i = 1'b1;
    address_i = addr;
    step();
    chk("rd_read_o", read_o, 1);
    chk("rd_write_o", write_o, 0);
    chk("rd_addr", address_o, exp_addr);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        address_i = $urandom;
        step();
        chk("rd_gap_read_o", read_o, 1);
        chk("rd_gap_write_o", write_o, 0);
        chk("rd_gap_resp_o", resp_o, 0);
        chk("rd_gap_addr", address_o, exp_addr);
        chk("rd_gap_line", line_o, exp_line);
      end
      resp_i = 1'b1;
      burst_i = beats[k];
      step();
      resp_i = 1'b0;
      burst_i = {32'($urandom), 32'($urandom)};
      exp_line[BW*k +: BW] = beats[k];
      if (k < 3) begin
        chk("rd_beat_read_o", read_o, 1);
        chk("rd_beat_line", line_o, exp_line);
      end
    end
    chk("rd_done_resp_o", resp_o, 1);
    chk("rd_done_read_o", read_o, 0);
    chk("rd_done_line", line_o, exp_line);
    read_i = 1'b0;
    step();
    chk("rd_idle_resp_o", resp_o, 0);
    chk("rd_idle_read_o", read_o, 0);
  endtask

  // Full write transaction; gap<0 means random gaps. next_read leaves read_i high into IDLE.
  task automatic do_write(input logic [LW-1:0] line, input int gap, input bit both, input bit next_read);
    logic [31:0] addr, exp_addr;
    logic [BW-1:0] eb;
    int g;
    addr = $urandom;
    exp_addr = addr & 32'hFFFF_FFE0;
    line_i = line;
    write_i = 1'b1;
    read_i = both;
    address_i = addr;
    step();
    chk("wr_write_o", write_o, 1);
    chk("wr_read_o", read_o, 0);
    chk("wr_addr", address_o, exp_addr);
    for (int k = 0; k < 4; k++) begin
      eb = BW'(line >> (BW * k));
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      repeat (g) begin
        chk("wr_gap_burst", burst_o, eb);
        address_i = $urandom;
        step();
        chk("wr_gap_write_o", write_o, 1);
        chk("wr_gap_addr", address_o, exp_addr);
      end
      chk("wr_beat_burst", burst_o, eb);
      resp_i = 1'b1;
      step();
      resp_i = 1'b0;
    end
    chk("wr_done_resp_o", resp_o, 1);
    chk("wr_done_write_o", write_o, 0);
    chk("wr_done_burst", burst_o, 0);
    chk("wr_done_line_o", line_o, exp_line);
    write_i = 1'b0;
    read_i = next_read;
    step();
    chk("wr_idle_resp_o", resp_o, 0);
    chk("wr_idle_write_o", write_o, 0);
    chk("wr_idle_read_o", read_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    exp_line = '0;
    #12;
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    step();
    chk_all_zero("post_reset");

    // Directed read, consecutive beats
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    read_i = 1'b1;
    address_i = 32'h1234_5678;
    step();
    chk("dir_addr", address_o, 32'h1234_5660);
    read_i = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_line = '0;
    do_read(32'h1234_5678, 0);
    chk("dir_line", line_o, {beats[3], beats[2], beats[1], beats[0]});

    // Directed write with 2-cycle gaps, then back-to-back read
    do_write({{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}}, 2, 1'b0, 1'b1);
    rand_beats();
    do_read($urandom, 1);

    // Stray resp_i in IDLE, then simultaneous read/write request
    resp_i = 1'b1;
    burst_i = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    resp_i = 1'b0;
    chk("stray_read_o", read_o, 0);
    chk("stray_write_o", write_o, 0);
    chk("stray_resp_o", resp_o, 0);
    chk("stray_line", line_o, exp_line);
    do_write(rand_line(), -1, 1'b1, 1'b0);
    rand_beats();
    do_read($urandom, 2);

    // Randomized mix of transactions
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        rand_beats();
        do_read($urandom, 3);
      end else begin
        do_write(rand_line(), -1, 1'($urandom_range(1, 0)), 1'b0);
      end
    end

    // Asynchronous reset after two read beats
    rand_beats();
    read_i = 1'b1;
    address_i = $urandom;
    step();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1;
      burst_i = beats[k];
      step();
      resp_i = 1'b0;
    end
    chk("midrd_read_o", read_o, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("midrd_reset");
    exp_line = '0;
    read_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_all_zero("midrd_idle");
    rand_beats();
    do_read($urandom, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
